// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned MATRIX_SIZE_DEF = 2;
  localparam int unsigned PIPE_DELAY_DEF  = 3;
  localparam int unsigned TILE_W_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  // States that consume the shared phase counter
  function automatic logic is_phase_state(input seq_state_t s);
    return (s == LOAD) || (s == STREAM) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Job handshake and array-control bus of the systolic sequencer.
interface systolic_sequencer_if
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int unsigned TILE_W      = TILE_W_DEF
);
  localparam int unsigned ROW_W = $clog2(MATRIX_SIZE);

  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              done;
  logic              wbuf_en;
  logic [ROW_W-1:0]  wbuf_row;
  logic              ibuf_en;
  logic              acc_clear;
  logic              result_valid;
  logic [TILE_W-1:0] tile_idx;

  modport master (
    output start, num_tiles,
    input  busy, done, wbuf_en, wbuf_row, ibuf_en, acc_clear, result_valid, tile_idx
  );

  modport slave (
    input  start, num_tiles,
    output busy, done, wbuf_en, wbuf_row, ibuf_en, acc_clear, result_valid, tile_idx
  );

endinterface

// File: rtl/seq_phase_counter.sv
// Phase counter shared by LOAD/STREAM/DRAIN: synchronous clear plus terminal-count flag.
module seq_phase_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] last_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign tc_o    = (cnt_q == last_i);

endmodule

// File: rtl/systolic_sequencer.sv
// Tile sequencer for an NxN systolic array: CLEAR/LOAD/STREAM/DRAIN per tile, then DONE.
// Optional feature: define SEQ_ABORT_EN to add the abort input.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int unsigned PIPE_DELAY  = PIPE_DELAY_DEF,
  parameter int unsigned TILE_W      = TILE_W_DEF
) (
  input logic clk,
  input logic reset_n,
`ifdef SEQ_ABORT_EN
  input logic abort,
`endif
  systolic_sequencer_if.slave bus
);

  localparam int unsigned ROW_W     = $clog2(MATRIX_SIZE);
  localparam int unsigned DRAIN_LEN = PIPE_DELAY + 2 * MATRIX_SIZE - 1;
  localparam int unsigned CNT_W     = $clog2(DRAIN_LEN + 1);

  seq_state_t        state_q, state_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] count_q, count_d;
  logic [TILE_W:0]   tile_inc_s;

  logic [CNT_W-1:0]  cnt_s, cnt_d_s, last_s;
  logic              tc_s, clr_s, abort_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wbuf_en_q, wbuf_en_d;
  logic [ROW_W-1:0]  wbuf_row_q, wbuf_row_d;
  logic              ibuf_en_q, ibuf_en_d;
  logic              acc_clear_q, acc_clear_d;
  logic              rvalid_q, rvalid_d;

`ifdef SEQ_ABORT_EN
  assign abort_s = abort && (state_q != IDLE);
`else
  assign abort_s = 1'b0;
`endif

  assign tile_inc_s = {1'b0, tile_q} + {{TILE_W{1'b0}}, 1'b1};

  seq_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_s),
    .last_i  (last_s),
    .cnt_o   (cnt_s),
    .cnt_d_o (cnt_d_s),
    .tc_o    (tc_s)
  );

  always_comb begin
    last_s = '0;
    case (state_q)
      LOAD, STREAM: last_s = CNT_W'(MATRIX_SIZE - 1);
      DRAIN:        last_s = CNT_W'(DRAIN_LEN - 1);
      default:      last_s = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    count_d = count_q;
    if (abort_s) begin
      state_d = IDLE;
      tile_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tile_d = '0;
          if (bus.start) begin
            count_d = bus.num_tiles;
            if (bus.num_tiles == '0) begin
              state_d = DONE;
            end else begin
              state_d = CLEAR;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: state_d = LOAD;
        LOAD: begin
          if (tc_s) state_d = STREAM;
          else      state_d = LOAD;
        end
        STREAM: begin
          if (tc_s) state_d = DRAIN;
          else      state_d = STREAM;
        end
        DRAIN: begin
          if (!tc_s) begin
            state_d = DRAIN;
          end else if (tile_inc_s < {1'b0, count_q}) begin
            tile_d  = tile_inc_s[TILE_W-1:0];
            state_d = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          tile_d  = '0;
        end
        default: begin
          state_d = IDLE;
          tile_d  = '0;
        end
      endcase
    end
  end

  // The counter restarts on every state change and idles at zero outside its phases
  assign clr_s = (state_d != state_q) || !is_phase_state(state_q);

  // Outputs are decoded from the next state so they leave the register aligned with it
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wbuf_en_d   = 1'b0;
    wbuf_row_d  = '0;
    ibuf_en_d   = 1'b0;
    acc_clear_d = 1'b0;
    rvalid_d    = 1'b0;
    case (state_d)
      IDLE:   busy_d = 1'b0;
      CLEAR: begin
        busy_d      = 1'b1;
        acc_clear_d = 1'b1;
      end
      LOAD: begin
        busy_d     = 1'b1;
        wbuf_en_d  = 1'b1;
        wbuf_row_d = cnt_d_s[ROW_W-1:0];
      end
      STREAM: begin
        busy_d    = 1'b1;
        ibuf_en_d = 1'b1;
      end
      DRAIN: begin
        busy_d   = 1'b1;
        rvalid_d = (cnt_d_s >= CNT_W'(PIPE_DELAY + MATRIX_SIZE - 1));
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tile_q      <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wbuf_en_q   <= 1'b0;
      wbuf_row_q  <= '0;
      ibuf_en_q   <= 1'b0;
      acc_clear_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wbuf_en_q   <= wbuf_en_d;
      wbuf_row_q  <= wbuf_row_d;
      ibuf_en_q   <= ibuf_en_d;
      acc_clear_q <= acc_clear_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wbuf_en      = wbuf_en_q;
  assign bus.wbuf_row     = wbuf_row_q;
  assign bus.ibuf_en      = ibuf_en_q;
  assign bus.acc_clear    = acc_clear_q;
  assign bus.result_valid = rvalid_q;
  assign bus.tile_idx     = tile_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer against a cycle-offset timeline model of each job.
module tb_systolic_sequencer;
  import systolic_pkg::*;

  localparam int M  = 2;
  localparam int PD = 3;
  localparam int TW = 8;
  localparam int P  = 1 + M + M + (PD + 2 * M - 1);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  systolic_sequencer_if #(.MATRIX_SIZE(M), .TILE_W(TW)) bus ();

`ifdef SEQ_ABORT_EN
  logic abort_s;
`endif

  systolic_sequencer #(.MATRIX_SIZE(M), .PIPE_DELAY(PD), .TILE_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef SEQ_ABORT_EN
    .abort   (abort_s),
`endif
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit job_act = 1'b0;
  int c0 = 0;
  int jn = 0;
  int cyc = 0;
  bit did_rst6 = 1'b0;

  int e_busy, e_done, e_wen, e_row, e_ien, e_clr, e_rv, e_tile;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs at cycle c from the job's offset since its accepting cycle
  task automatic compute_exp(input int c);
    int k, endk, t, p;
    e_busy = 0; e_done = 0; e_wen = 0; e_row = 0; e_ien = 0; e_clr = 0; e_rv = 0; e_tile = 0;
    if (job_act) begin
      k    = c - c0;
      endk = (jn == 0) ? 1 : jn * P + 1;
      if (k >= 1 && k < endk) begin
        t = (k - 1) / P;
        p = (k - 1) % P;
        e_busy = 1;
        e_tile = t;
        e_clr  = (p == 0) ? 1 : 0;
        if (p >= 1 && p <= M) begin
          e_wen = 1;
          e_row = p - 1;
        end
        e_ien = (p > M && p <= 2 * M) ? 1 : 0;
        e_rv  = (p >= P - M) ? 1 : 0;
      end else if (k == endk) begin
        e_busy = 1;
        e_done = 1;
        e_tile = (jn == 0) ? 0 : jn - 1;
      end
    end
  endtask

  task automatic check_all(input string pfx);
    check_val({pfx, ".busy"},      32'(bus.busy),         32'(e_busy));
    check_val({pfx, ".done"},      32'(bus.done),         32'(e_done));
    check_val({pfx, ".wbuf_en"},   32'(bus.wbuf_en),      32'(e_wen));
    check_val({pfx, ".wbuf_row"},  32'(bus.wbuf_row),     32'(e_row));
    check_val({pfx, ".ibuf_en"},   32'(bus.ibuf_en),      32'(e_ien));
    check_val({pfx, ".acc_clear"}, 32'(bus.acc_clear),    32'(e_clr));
    check_val({pfx, ".rvalid"},    32'(bus.result_valid), 32'(e_rv));
    check_val({pfx, ".tile_idx"},  32'(bus.tile_idx),     32'(e_tile));
  endtask

  task automatic pulse_reset();
    bus.start = 1'b0;
    reset_n   = 1'b0;
    job_act   = 1'b0;
    #1;
    compute_exp(cyc);
    check_all("rst_async");
    @(posedge clk);
    cyc++;
    #1;
    check_all("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.num_tiles = '0;
`ifdef SEQ_ABORT_EN
    abort_s = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    compute_exp(cyc);
    check_all("reset");
    reset_n = 1'b1;

    for (int it = 0; it < 900; it++) begin
      @(posedge clk);
      #1;
      cyc++;
      compute_exp(cyc);
      check_all("run");

      if ((!did_rst6 && it >= 60 && job_act && (cyc - c0 == 6)) ||
          (it >= 150 && $urandom_range(0, 99) == 0)) begin
        did_rst6 = did_rst6 || (it >= 60);
        pulse_reset();
        continue;
      end

      if (it < 40) begin
        bus.start     = 1'b1;
        bus.num_tiles = 8'd1;
      end else if (it < 60) begin
        bus.start     = 1'b0;
        bus.num_tiles = 8'($urandom_range(0, 255));
      end else if (it == 60) begin
        bus.start     = 1'b1;
        bus.num_tiles = 8'd3;
      end else if (it == 110) begin
        bus.start     = 1'b1;
        bus.num_tiles = 8'd0;
      end else if (it < 120) begin
        bus.start     = (it % 7 == 0) ? 1'b1 : 1'b0;
        bus.num_tiles = 8'($urandom_range(0, 3));
      end else begin
        bus.start     = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        bus.num_tiles = 8'($urandom_range(0, 3));
      end

`ifdef SEQ_ABORT_EN
      abort_s = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      if (e_busy != 0 && abort_s) begin
        job_act = 1'b0;
      end else
`endif
      if (e_busy == 0 && bus.start) begin
        job_act = 1'b1;
        c0      = cyc;
        jn      = int'(bus.num_tiles);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
